// File: rtl/fpu_div_pkg.sv
// ----------------------------------------------------------------------------
// fpu_div_pkg
// Shared definitions for the divider normalise/round back end: rounding-mode
// and special-case encodings, result flag bit positions, IEEE-754 single
// constants and the S1 -> S2 pipeline payload.
// ----------------------------------------------------------------------------
package fpu_div_pkg;

    typedef enum logic [2:0] {
        RmRne = 3'b000,
        RmRtz = 3'b001,
        RmRdn = 3'b010,
        RmRup = 3'b011,
        RmRmm = 3'b100
    } rm_e;

    typedef enum logic [1:0] {
        SpNormal = 2'b00,
        SpZero   = 2'b01,
        SpInf    = 2'b10,
        SpNan    = 2'b11
    } special_e;

    // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector.
    localparam int unsigned FlagNv = 4;
    localparam int unsigned FlagDz = 3;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagUf = 1;
    localparam int unsigned FlagNx = 0;

    localparam logic [31:0] CanonicalNan = 32'h7FC0_0000;
    localparam int unsigned ExpBias      = 127;

    // Normalised operand held in S1: 23-bit fraction (hidden 1 implied),
    // guard/sticky for rounding and a sign-extended exponent that may be
    // out of the representable range in either direction.
    typedef struct packed {
        logic               sign;
        logic [2:0]         rm;
        special_e           special;
        logic [1:0]         flags;
        logic signed [10:0] expo;
        logic [22:0]        mant;
        logic               guard;
        logic               sticky;
    } norm_t;

endpackage

// File: rtl/fpu_div_rounder.sv
// ----------------------------------------------------------------------------
// fpu_div_rounder
// Combinational round/pack of a normalised quotient into an IEEE-754 single.
// Handles special operands, overflow saturation per rounding mode and tiny
// results (gradual underflow when FPU_DIV_SUBNORMAL_EN is defined, otherwise
// flush to signed zero).
//   norm_i   : normalised operand from S1
//   result_o : packed single-precision result
//   flags_o  : {NV, DZ, OF, UF, NX}
// Build option: FPU_DIV_SUBNORMAL_EN enables subnormal outputs.
// ----------------------------------------------------------------------------
module fpu_div_rounder
    import fpu_div_pkg::*;
(
    input  norm_t       norm_i,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);

    localparam logic signed [11:0] ExpMax = 12'(2 * ExpBias + 1);

    logic [23:0]        sig;
    logic               g;
    logic               s;
    logic               inc;
    logic               inexact;
    logic               tiny;
    logic [24:0]        sum;
    logic signed [11:0] exp_ext;
    logic signed [11:0] exp_post;
    logic [31:0]        max_finite;
    logic [31:0]        infinity;
`ifdef FPU_DIV_SUBNORMAL_EN
    logic signed [11:0] sh_full;
    logic [4:0]         sh;
    logic [49:0]        wide;
`endif

    always_comb begin
        sig      = {1'b1, norm_i.mant};
        g        = norm_i.guard;
        s        = norm_i.sticky;
        exp_ext  = {norm_i.expo[10], norm_i.expo};
        // Tininess is judged on the normalised exponent, before rounding.
        tiny     = (exp_ext <= 12'sd0);

`ifdef FPU_DIV_SUBNORMAL_EN
        // Denormalise: shift hidden 1 + fraction + guard right by 1-exp.
        // The low half of 'wide' collects everything shifted out.
        sh_full = 12'sd1 - exp_ext;
        sh      = (sh_full > 12'sd26) ? 5'd26 : sh_full[4:0];
        wide    = {1'b1, norm_i.mant, norm_i.guard, 25'd0} >> sh;
        if (tiny) begin
            sig = wide[49:26];
            g   = wide[25];
            s   = norm_i.sticky | (|wide[24:0]);
        end
`endif

        inexact = g | s;

        case (norm_i.rm)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = norm_i.sign & inexact;
            RmRup:   inc = ~norm_i.sign & inexact;
            RmRmm:   inc = g;
            default: inc = g & (s | sig[0]);  // RNE, also reserved codes
        endcase

        // A carry into bit 24 leaves sum[23:0] all zero: fraction cleared.
        sum      = {1'b0, sig} + {24'd0, inc};
        exp_post = sum[24] ? (exp_ext + 12'sd1) : exp_ext;

        max_finite = {norm_i.sign, 31'h7F7F_FFFF};
        infinity   = {norm_i.sign, 8'hFF, 23'd0};

        result_o         = '0;
        flags_o          = '0;
        flags_o[FlagNv]  = norm_i.flags[1];
        flags_o[FlagDz]  = norm_i.flags[0];

        case (norm_i.special)
            SpZero:  result_o = {norm_i.sign, 31'd0};
            SpInf:   result_o = infinity;
            SpNan:   result_o = CanonicalNan;
            default: begin
                if (tiny) begin
`ifdef FPU_DIV_SUBNORMAL_EN
                    // sum[23] set means rounding reached the minimum normal.
                    result_o        = {norm_i.sign, 7'd0, sum[23], sum[22:0]};
                    flags_o[FlagUf] = inexact;
                    flags_o[FlagNx] = inexact;
`else
                    result_o        = {norm_i.sign, 31'd0};
                    flags_o[FlagUf] = 1'b1;
                    flags_o[FlagNx] = 1'b1;
`endif
                end else if (exp_post >= ExpMax) begin
                    flags_o[FlagOf] = 1'b1;
                    flags_o[FlagNx] = 1'b1;
                    case (norm_i.rm)
                        RmRtz:   result_o = max_finite;
                        RmRdn:   result_o = norm_i.sign ? infinity : max_finite;
                        RmRup:   result_o = norm_i.sign ? max_finite : infinity;
                        default: result_o = infinity;
                    endcase
                end else begin
                    result_o        = {norm_i.sign, exp_post[7:0], sum[22:0]};
                    flags_o[FlagNx] = inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fpu_div_norm_round.sv
// ----------------------------------------------------------------------------
// fpu_div_norm_round
// Two-stage valid/ready back end for the FP divider. S1 normalises the raw
// quotient (26-bit fraction + sticky) to a 23-bit fraction with guard and
// sticky; S2 rounds and packs through fpu_div_rounder into registered outputs.
//   clk, reset (async, active low)
//   in_valid/in_ready : quotient handshake
//   in_quot, in_exp, in_sign, in_rm, in_special, in_flags : operand payload
//   out_valid/out_ready : result handshake
//   out_result, out_flags : IEEE single and {NV, DZ, OF, UF, NX}
// Build option: FPU_DIV_SUBNORMAL_EN enables subnormal outputs (in rounder).
// ----------------------------------------------------------------------------
module fpu_div_norm_round
    import fpu_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_quot,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic [2:0]  in_rm,
    input  logic [1:0]  in_special,
    input  logic [1:0]  in_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    norm_t              norm_in;
    norm_t              s1_d;
    norm_t              s1_q;
    logic               s1_valid_d;
    logic               s1_valid_q;
    logic               s2_valid_d;
    logic               s2_valid_q;
    logic [31:0]        out_result_d;
    logic [31:0]        out_result_q;
    logic [4:0]         out_flags_d;
    logic [4:0]         out_flags_q;
    logic [31:0]        rnd_result;
    logic [4:0]         rnd_flags;
    logic               s1_adv;
    logic               accept;
    logic signed [10:0] exp_in_ext;

    // S1 normalisation: the quotient lies in [0.5, 2), so at most one
    // left shift (with exponent decrement) is needed.
    always_comb begin
        exp_in_ext      = {in_exp[9], in_exp};
        norm_in.sign    = in_sign;
        norm_in.rm      = in_rm;
        norm_in.special = special_e'(in_special);
        norm_in.flags   = in_flags;
        if (in_quot[26]) begin
            norm_in.mant   = in_quot[25:3];
            norm_in.guard  = in_quot[2];
            norm_in.sticky = |in_quot[1:0];
            norm_in.expo   = exp_in_ext;
        end else begin
            norm_in.mant   = in_quot[24:2];
            norm_in.guard  = in_quot[1];
            norm_in.sticky = in_quot[0];
            norm_in.expo   = exp_in_ext - 11'sd1;
        end
    end

    fpu_div_rounder u_rounder (
        .norm_i   (s1_q),
        .result_o (rnd_result),
        .flags_o  (rnd_flags)
    );

    always_comb begin
        // S1 may move on when the output register is empty or being drained.
        s1_adv       = !s2_valid_q || out_ready;
        in_ready     = !s1_valid_q || s1_adv;
        accept       = in_valid && in_ready;

        s1_d         = s1_q;
        s1_valid_d   = s1_valid_q;
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = rnd_result;
                out_flags_d  = rnd_flags;
            end
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_d       = norm_in;
            s1_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_q         <= s1_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fpu_div_norm_round.sv
// Scoreboard bench for fpu_div_norm_round: directed vectors push expected
// results into a queue; a monitor pops and compares on each output transfer.
module tb_fpu_div_norm_round;

    localparam logic [4:0] Nx = 5'b00001;
    localparam logic [4:0] Uf = 5'b00010;
    localparam logic [4:0] Of = 5'b00100;
    localparam logic [4:0] Dz = 5'b01000;
    localparam logic [4:0] Nv = 5'b10000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_quot = '0;
    logic [9:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic [2:0]  in_rm = '0;
    logic [1:0]  in_special = '0;
    logic [1:0]  in_flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    fpu_div_norm_round dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_quot    (in_quot),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .in_rm      (in_rm),
        .in_special (in_special),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nout = 0;
    bit          prev_held = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_flg;
    exp_t        mon_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (out_valid) begin
            if (prev_held) begin
                chk($sformatf("hold_result[%0d]", nout), out_result, held_res);
                chk($sformatf("hold_flags[%0d]", nout), {27'd0, out_flags}, {27'd0, held_flg});
            end else if (sb_q.size() > 0 && sb_q[0].lat) begin
                chk($sformatf("latency[%0d]", nout), cyc, sb_q[0].acc + 2);
            end
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("unexpected_output[%0d]", nout), out_result, 32'hxxxx_xxxx);
                end else begin
                    mon_x = sb_q.pop_front();
                    chk($sformatf("result[%0d]", nout), out_result, mon_x.res);
                    chk($sformatf("flags[%0d]", nout), {27'd0, out_flags}, {27'd0, mon_x.flg});
                end
                nout++;
            end
            prev_held = !out_ready;
            held_res  = out_result;
            held_flg  = out_flags;
        end else begin
            prev_held = 1'b0;
        end
    end

    task automatic issue(input logic [26:0] quot, input logic [9:0] e, input logic s,
                         input logic [2:0] rm, input logic [1:0] sp, input logic [1:0] fl,
                         input logic [31:0] res, input logic [4:0] flg,
                         input bit push, input bit lat);
        int   waited;
        exp_t x;
        @(negedge clk);
        in_quot    = quot;
        in_exp     = e;
        in_sign    = s;
        in_rm      = rm;
        in_special = sp;
        in_flags   = fl;
        in_valid   = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready got 0, required 1");
            in_valid = 1'b0;
        end else begin
            x.res = res;
            x.flg = flg;
            x.acc = cyc;
            x.lat = lat;
            @(posedge clk);
            if (push) sb_q.push_back(x);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_flags", {27'd0, out_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic values, rounding and overflow.
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F80_0000, 5'd0, 1, 1);
        issue(27'h2000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F00_0000, 5'd0, 1, 0);
        issue(27'h4000004, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F80_0000, Nx, 1, 0);
        issue(27'h4000004, 10'd127, 1'b0, 3'b011, 2'b00, 2'b00, 32'h3F80_0001, Nx, 1, 0);
        issue(27'h400000C, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F80_0002, Nx, 1, 0);
        issue(27'h4000004, 10'd127, 1'b0, 3'b100, 2'b00, 2'b00, 32'h3F80_0001, Nx, 1, 0);
        issue(27'h4000004, 10'd127, 1'b0, 3'b101, 2'b00, 2'b00, 32'h3F80_0000, Nx, 1, 0);
        issue(27'h4000004, 10'd127, 1'b1, 3'b010, 2'b00, 2'b00, 32'hBF80_0001, Nx, 1, 0);
        issue(27'h7FFFFFC, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h4000_0000, Nx, 1, 0);
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b10, 32'h3F80_0000, Nv, 1, 0);
        issue(27'h4000000, 10'd300, 1'b0, 3'b000, 2'b00, 2'b00, 32'h7F80_0000, Of | Nx, 1, 0);
        issue(27'h4000000, 10'd300, 1'b0, 3'b001, 2'b00, 2'b00, 32'h7F7F_FFFF, Of | Nx, 1, 0);
        issue(27'h4000000, 10'd300, 1'b1, 3'b010, 2'b00, 2'b00, 32'hFF80_0000, Of | Nx, 1, 0);
        issue(27'h4000000, 10'd300, 1'b1, 3'b011, 2'b00, 2'b00, 32'hFF7F_FFFF, Of | Nx, 1, 0);
        // Specials.
        issue(27'h4000000, 10'd127, 1'b1, 3'b000, 2'b01, 2'b01, 32'h8000_0000, Dz, 1, 0);
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b10, 2'b01, 32'h7F80_0000, Dz, 1, 0);
        // Tiny results.
`ifdef FPU_DIV_SUBNORMAL_EN
        issue(27'h4000000, 10'd0, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0040_0000, 5'd0, 1, 0);
        issue(27'h4000004, 10'd0, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0040_0000, Uf | Nx, 1, 0);
        issue(27'h7FFFFFC, 10'd0, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0080_0000, Uf | Nx, 1, 0);
`else
        issue(27'h4000000, 10'd0, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0000_0000, Uf | Nx, 1, 0);
        issue(27'h4000004, 10'd0, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0000_0000, Uf | Nx, 1, 0);
        issue(27'h7FFFFFC, 10'd0, 1'b1, 3'b000, 2'b00, 2'b00, 32'h8000_0000, Uf | Nx, 1, 0);
`endif
        idle();
        drain();

        // Back-pressure: out_ready low for 4 cycles while issuing 3 ops.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F80_0000, 5'd0, 1, 0);
        issue(27'h2000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h3F00_0000, 5'd0, 1, 0);
        @(negedge clk);
        #1;
        chk("backpressure_in_ready", {31'd0, in_ready}, 32'd0);
        issue(27'h4000000, 10'd128, 1'b0, 3'b000, 2'b00, 2'b00, 32'h4000_0000, 5'd0, 1, 0);
        idle();
        drain();

        // Reset with both stages full: in-flight results are discarded.
        @(negedge clk);
        out_ready = 1'b0;
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0, 5'd0, 0, 0);
        issue(27'h2000000, 10'd127, 1'b0, 3'b000, 2'b00, 2'b00, 32'h0, 5'd0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_out_result", out_result, 32'd0);
        chk("midreset_out_flags", {27'd0, out_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        issue(27'h4000000, 10'd127, 1'b0, 3'b000, 2'b11, 2'b10, 32'h7FC0_0000, Nv, 1, 1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_div_norm_round.md
FPU_DIV_NORM_ROUND -- requirements
Module: fpu_div_norm_round

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  input  1  quotient available; divider rdy pulse qualified by control.
REQ-004 SHALL have: in_ready  output  1  block accepts the input this cycle.
REQ-005 SHALL have: in_quot  input  27  quotient; [26] weighs 2^0, [25:1] fraction bits, [0] sticky.
REQ-006 SHALL have: in_exp  input  10  signed, biased, pre-normalisation result exponent.
REQ-007 SHALL have: in_sign  input  1  result sign.
REQ-008 SHALL have: in_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 SHALL have: in_special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN.
REQ-010 SHALL have: in_flags  input  2  {NV, DZ} pass-through from operand check.
REQ-011 SHALL have: out_valid  output  1  result valid.
REQ-012 SHALL have: out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have: out_result  output  32  IEEE-754 single-precision result.
REQ-014 SHALL have: out_flags  output  5  {NV, DZ, OF, UF, NX}.

Function
REQ-015 SHALL be a two-stage valid/ready pipeline: S1 normalise, S2 round/pack; transfers occur when valid && ready.
REQ-016 SHALL deliver out_valid 2 cycles after input acceptance when out_ready stays high; throughput 1 per cycle.
REQ-017 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; S1 advances only when S2 is empty or draining.
REQ-018 SHALL hold out_result and out_flags stable while out_valid && !out_ready.
REQ-019 S1: if in_quot[26]=1, mant = [25:3], guard = [2], sticky = |[1:0]; else mant = [24:2], guard = [1], sticky = [0], exp = in_exp-1.
REQ-020 S2 SHALL round with guard/sticky per in_rm; RNE breaks ties to even; RMM breaks ties away; RDN/RUP use sign; codes 101-111 SHALL act as RNE.
REQ-021 Mantissa carry-out on rounding SHALL increment the exponent and clear the mantissa.
REQ-022 Post-round exp >= 255: OF+NX; RNE/RMM -> infinity; RTZ -> max finite 0x7F7FFFFF|sign; RDN/RUP -> infinity toward the rounding direction, else max finite.
REQ-023 NX SHALL be set whenever guard|sticky is nonzero at the rounding point.
REQ-024 Special 01 -> signed zero, 10 -> signed infinity, 11 -> 0x7FC00000; OF/UF/NX cleared; in_flags passed through unchanged.
REQ-025 For normal inputs, NV and DZ SHALL equal in_flags.
REQ-026 Tininess SHALL be detected before rounding (normalised exp <= 0).

Reset
REQ-027 Asserted reset SHALL clear s1_valid, s2_valid and out_valid to 0, and out_result and out_flags to 0, immediately.
REQ-028 Reset mid-operation SHALL discard in-flight results; the first accepted input after release SHALL emerge correctly.
REQ-029 in_ready SHALL be 1 while reset is asserted.

Configuration
REQ-030 With FPU_DIV_SUBNORMAL_EN defined, tiny results SHALL right-shift the mantissa (hidden 1 included) by 1-exp, saturating at 26, ORing shifted-out bits into sticky, then round with exp field 0; rounding up into 2^-126 SHALL yield the minimum normal.
REQ-031 With FPU_DIV_SUBNORMAL_EN defined, UF SHALL be set when tiny and inexact.
REQ-032 Without FPU_DIV_SUBNORMAL_EN, tiny results SHALL flush to signed zero with UF and NX set.

Structure
REQ-033 Package fpu_div_pkg SHALL hold rounding-mode encodings, special codes, flag bit positions, canonical NaN 0x7FC00000, and bias 127.
REQ-034 Round/pack logic SHALL be one combinational sub-module fpu_div_rounder instantiated in S2.

Verification
REQ-035 in_quot=27'h4000000, exp=127, sign=0, RNE -> 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
REQ-036 in_quot=27'h2000000, exp=127 -> 0x3F000000; in_quot=27'h4000004 -> RNE 0x3F800000 NX, RUP 0x3F800001 NX.
REQ-037 in_quot=27'h4000000, exp=300: RNE -> 0x7F800000 OF|NX; RTZ -> 0x7F7FFFFF OF|NX.
REQ-038 in_quot=27'h4000000, exp=0: with macro -> 0x00400000, flags 0; without macro -> 0x00000000 UF|NX.
REQ-039 Hold out_ready low 4 cycles while issuing 3 operations -> in_ready falls after 2 are held, no loss, in-order delivery, stable outputs.
REQ-040 Assert reset with both stages full -> out_valid low at once; next operation completes in 2 cycles; special 11 -> 0x7FC00000 with in_flags NV.
